// File: rtl/pq_sreg_queue.sv
// Sorted shift-register priority queue: slot 0 always holds the best entry.
// Latency: one cycle from enq/deq to updated kv_out/count; one operation per cycle.
// Never stalls: full/empty misuse is dropped and reported on ovf/udf/key_err pulses.
package pq_pkg;
    localparam int KEY_W       = 8;
    localparam int VAL_W       = 8;
    localparam int PQ_CAPACITY = 16;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [VAL_W-1:0] val_t;

    typedef struct packed {
        key_t key;
        val_t val;
    } kv_t;

    typedef enum logic {MIN_PQ = 1'b0, MAX_PQ = 1'b1} pq_type_e;

    localparam pq_type_e PQ_TYPE = MIN_PQ;

    // The key that can never be stored; it also marks unused slots.
    localparam key_t KEYINF   = (PQ_TYPE == MIN_PQ) ? {KEY_W{1'b1}} : {KEY_W{1'b0}};
    localparam kv_t  KV_EMPTY = '{key: KEYINF, val: '0};

    // True when a has strictly higher priority than b.
    function automatic logic cmp_kv_gt(input kv_t a, input kv_t b);
        if (PQ_TYPE == MIN_PQ) begin
            return a.key < b.key;
        end
        return a.key > b.key;
    endfunction
endpackage

module pq_sreg_queue
    import pq_pkg::*;
#(
    parameter int CAPACITY = PQ_CAPACITY
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enq,
    input  kv_t                           kv_in,
    input  logic                          deq,
    output kv_t                           kv_out,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(CAPACITY+1)-1:0] count,
    output logic                          ovf,
    output logic                          udf,
    output logic                          key_err
);
    localparam int CW = $clog2(CAPACITY + 1);

    kv_t           slot_q [CAPACITY];
    kv_t           slot_d [CAPACITY];
    kv_t           base   [CAPACITY];
    logic [CW-1:0] cnt_q, cnt_d, base_cnt;
    logic [CAPACITY-1:0] keep;
    logic          deq_eff, ins_eff, key_ok;
    logic          ovf_q, udf_q, key_err_q;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(CAPACITY));
    assign count   = cnt_q;
    assign kv_out  = slot_q[0];
    assign ovf     = ovf_q;
    assign udf     = udf_q;
    assign key_err = key_err_q;

    // Next array: optionally pop slot 0, then optionally insert kv_in behind all
    // entries of equal or better priority (keeps FIFO order among equal keys).
    always_comb begin
        deq_eff = deq && !empty;
        key_ok  = (kv_in.key != KEYINF);
        ins_eff = enq && key_ok && (!full || deq_eff);

        for (int i = 0; i < CAPACITY - 1; i++) begin
            base[i] = deq_eff ? slot_q[i+1] : slot_q[i];
        end
        base[CAPACITY-1] = deq_eff ? KV_EMPTY : slot_q[CAPACITY-1];
        base_cnt = cnt_q - CW'(deq_eff);

        // keep[i]: entry i stays put because it ranks at or above kv_in.
        for (int i = 0; i < CAPACITY; i++) begin
            keep[i] = (CW'(i) < base_cnt) && !cmp_kv_gt(kv_in, base[i]);
        end

        if (!ins_eff || keep[0]) begin
            slot_d[0] = base[0];
        end else begin
            slot_d[0] = kv_in;
        end
        for (int i = 1; i < CAPACITY; i++) begin
            if (!ins_eff || keep[i]) begin
                slot_d[i] = base[i];
            end else if (keep[i-1]) begin
                slot_d[i] = kv_in;
            end else begin
                slot_d[i] = base[i-1];
            end
        end

        cnt_d = base_cnt + CW'(ins_eff);
    end

    // Slot array and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CAPACITY; i++) begin
                slot_q[i] <= KV_EMPTY;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < CAPACITY; i++) begin
                slot_q[i] <= slot_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    // Error pulses, each raised independently for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            ovf_q     <= enq && !deq && full;
            udf_q     <= deq && empty;
            key_err_q <= enq && !key_ok;
        end
    end
endmodule

// File: tb/tb_pq_sreg_queue.sv
// Bench for pq_sreg_queue (MIN_PQ, 16 entries, 8-bit key/value).
// Outputs are compared against a sorted-queue model on every falling edge.
// Directed scenarios pin the model with literal expected values.
module tb_pq_sreg_queue;
    import pq_pkg::*;

    localparam int CAP = 16;

    logic       clk;
    logic       rst_n;
    logic       enq;
    kv_t        kv_in;
    logic       deq;
    kv_t        kv_out;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       ovf;
    logic       udf;
    logic       key_err;

    int checks   = 0;
    int failures = 0;

    kv_t m[$];
    logic exp_ovf = 1'b0;
    logic exp_udf = 1'b0;
    logic exp_kerr = 1'b0;
    logic cmp_en = 1'b0;

    pq_sreg_queue #(.CAPACITY(CAP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enq     (enq),
        .kv_in   (kv_in),
        .deq     (deq),
        .kv_out  (kv_out),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf),
        .udf     (udf),
        .key_err (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: a plain list ordered by ascending key, ties kept in arrival order.
    task automatic model_update(input logic e, input kv_t k, input logic d);
        int  sz;
        logic popped;
        int  pos;
        sz       = m.size();
        exp_ovf  = e && !d && (sz == CAP);
        exp_udf  = d && (sz == 0);
        exp_kerr = e && (k.key == 8'hFF);
        popped   = 1'b0;
        if (d && sz > 0) begin
            void'(m.pop_front());
            popped = 1'b1;
        end
        if (e && k.key != 8'hFF && (sz < CAP || popped)) begin
            pos = m.size();
            for (int i = 0; i < m.size(); i++) begin
                if (m[i].key > k.key) begin
                    pos = i;
                    break;
                end
            end
            m.insert(pos, k);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            kv_t exp_kv;
            exp_kv = (m.size() > 0) ? m[0] : '{key: 8'hFF, val: 8'h00};
            chk("kv_out", 32'(kv_out), 32'(exp_kv));
            chk("count", 32'(count), 32'(m.size()));
            chk("empty", 32'(empty), 32'(m.size() == 0));
            chk("full", 32'(full), 32'(m.size() == CAP));
            chk("ovf", 32'(ovf), 32'(exp_ovf));
            chk("udf", 32'(udf), 32'(exp_udf));
            chk("key_err", 32'(key_err), 32'(exp_kerr));
        end
    end

    // Apply one request for one clock; returns 1 time unit after the edge.
    task automatic step(input logic e, input logic [7:0] k, input logic [7:0] v, input logic d);
        kv_t kv;
        kv    = '{key: k, val: v};
        enq   = e;
        kv_in = kv;
        deq   = d;
        @(posedge clk);
        model_update(e, kv, d);
        #1;
        enq = 1'b0;
        deq = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        m.delete();
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        exp_kerr = 1'b0;
        enq      = 1'b1;
        kv_in    = '{key: 8'h03, val: 8'h33};
        deq      = 1'b1;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_kv_out", 32'(kv_out), 32'h0000FF00);
        @(posedge clk);
        #1;
        enq   = 1'b0;
        deq   = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enq    = 1'b0;
        deq    = 1'b0;
        kv_in  = '{key: 8'h00, val: 8'h00};
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset.
        step(1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0);
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_kv_out", 32'(kv_out), 32'h0000FF00);
        chk("idle_errs", {29'd0, ovf, udf, key_err}, 32'd0);

        // Ordering with a tie on key 2.
        step(1'b1, 8'd5, 8'd1, 1'b0);
        step(1'b1, 8'd2, 8'd2, 1'b0);
        step(1'b1, 8'd9, 8'd3, 1'b0);
        step(1'b1, 8'd2, 8'd4, 1'b0);
        chk("ord_head0", 32'(kv_out), 32'h00000202);
        chk("ord_count", 32'(count), 32'd4);
        step(1'b0, 8'd0, 8'd0, 1'b1);
        chk("ord_head1", 32'(kv_out), 32'h00000204);
        step(1'b0, 8'd0, 8'd0, 1'b1);
        chk("ord_head2", 32'(kv_out), 32'h00000501);
        step(1'b0, 8'd0, 8'd0, 1'b1);
        chk("ord_head3", 32'(kv_out), 32'h00000903);
        step(1'b0, 8'd0, 8'd0, 1'b1);
        chk("ord_empty", 32'(empty), 32'd1);

        // Fill, overflow, then replace while full.
        for (int i = 0; i < CAP; i++) begin
            step(1'b1, 8'(8'd10 + i), 8'(i), 1'b0);
        end
        chk("fill_full", 32'(full), 32'd1);
        step(1'b1, 8'd3, 8'hAA, 1'b0);
        chk("ovf_pulse", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_head", 32'(kv_out), 32'h00000A00);
        step(1'b1, 8'd0, 8'h55, 1'b1);
        chk("ovf_clear", 32'(ovf), 32'd0);
        chk("repl_count", 32'(count), 32'd16);
        chk("repl_head", 32'(kv_out), 32'h00000055);
        for (int i = 0; i < CAP; i++) begin
            step(1'b0, 8'd0, 8'd0, 1'b1);
        end

        // Underflow, and enq+deq on an empty queue.
        step(1'b0, 8'd0, 8'd0, 1'b1);
        chk("udf_pulse", 32'(udf), 32'd1);
        chk("udf_count", 32'(count), 32'd0);
        step(1'b1, 8'd7, 8'h11, 1'b1);
        chk("udf_enq_pulse", 32'(udf), 32'd1);
        chk("udf_enq_count", 32'(count), 32'd1);
        chk("udf_enq_head", 32'(kv_out), 32'h00000711);

        // Reserved key rejected; concurrent deq still honoured.
        step(1'b1, 8'hFF, 8'h22, 1'b0);
        chk("kerr_pulse", 32'(key_err), 32'd1);
        chk("kerr_count", 32'(count), 32'd1);
        step(1'b1, 8'hFF, 8'h22, 1'b1);
        chk("kerr_deq_pulse", 32'(key_err), 32'd1);
        chk("kerr_deq_count", 32'(count), 32'd0);

        // Random stream with a mid-stream reset.
        for (int n = 0; n < 10000; n++) begin
            logic       e;
            logic       d;
            logic [7:0] k;
            int         ep;
            if (n == 5000) begin
                do_reset();
            end
            ep = ((n % 2000) < 600) ? 80 : (((n % 2000) < 1200) ? 25 : 55);
            e  = ($urandom_range(0, 99) < ep);
            d  = ($urandom_range(0, 99) < (100 - ep));
            k  = ($urandom_range(0, 24) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            step(e, k, 8'($urandom_range(0, 255)), d);
        end

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pq_sreg_queue.md
PQ_SREG_QUEUE -- requirements
Module: pq_sreg_queue

Interface
REQ-001 The block SHALL take parameter CAPACITY, default pq_pkg::PQ_CAPACITY (16), the number of <key,value> entries held.
REQ-002 The block SHALL take all key/value types, PQ_TYPE, KV_EMPTY, KEYINF and cmp_kv_gt from pq_pkg, with no local redefinition.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enq  input  1  enqueue request, sampled each cycle.
REQ-006 kv_in  input  kv_t  pair to enqueue; valid when enq=1.
REQ-007 deq  input  1  dequeue request for the highest-priority entry.
REQ-008 kv_out  output  kv_t  current highest-priority entry (slot 0); KV_EMPTY when empty.
REQ-009 empty  output  1  count==0.
REQ-010 full  output  1  count==CAPACITY.
REQ-011 count  output  $clog2(CAPACITY+1)  number of valid entries.
REQ-012 ovf  output  1  one-cycle pulse: enqueue dropped because the queue was full.
REQ-013 udf  output  1  one-cycle pulse: dequeue ignored because the queue was empty.
REQ-014 key_err  output  1  one-cycle pulse: enqueue rejected because kv_in.key==KEYINF.

Function
REQ-015 Storage SHALL be a CAPACITY-slot register array kept sorted by cmp_kv_gt, slot 0 highest priority; unused slots SHALL hold KV_EMPTY.
REQ-016 kv_out SHALL be driven directly from the slot-0 register, so a result is visible the cycle after the operation that produced it (1-cycle latency, 1 op/cycle, no stall).
REQ-017 Enqueue only (enq=1, deq=0, not full, key valid): kv_in SHALL be inserted after every entry with an equal or higher-priority key (FIFO among equal keys), lower entries shifting down one slot; count+1.
REQ-018 Dequeue only (deq=1, enq=0, not empty): slots 1..CAPACITY-1 SHALL shift up one slot, last slot loads KV_EMPTY; count-1.
REQ-019 Replace (enq=1, deq=1, not empty, key valid): slot 0 SHALL be discarded and kv_in inserted into the remaining entries per the REQ-017 ordering, in one cycle; count unchanged; legal when full.
REQ-020 enq=1, deq=0 when full: array and count SHALL be unchanged; ovf=1 next cycle.
REQ-021 deq=1 when empty: dequeue ignored, udf=1 next cycle; if enq=1 with a valid key in the same cycle, the enqueue SHALL still be performed.
REQ-022 enq=1 with kv_in.key==KEYINF: the insert SHALL be suppressed and key_err=1 next cycle; a simultaneous deq on a non-empty queue SHALL still be performed as dequeue-only.
REQ-023 Error pulses SHALL be registered, high exactly one cycle per offending request, and independent of one another.
REQ-024 count SHALL never exceed CAPACITY nor wrap below 0.
REQ-025 Behaviour SHALL follow PQ_TYPE only through cmp_kv_gt/KEYINF; the same RTL SHALL serve MIN_PQ and MAX_PQ.

Reset
REQ-026 While rst_n=0, asynchronously: all slots=KV_EMPTY, count=0, empty=1, full=0, kv_out=KV_EMPTY, ovf=udf=key_err=0.
REQ-027 Reset asserted mid-operation SHALL discard all contents and any in-flight request; the first request is accepted on the first rising edge with rst_n=1.

Verification (MIN_PQ, CAPACITY=16, KEY/VAL 8 bits)
REQ-028 Reset then idle -> empty=1, count=0, kv_out={FF,00}, no error pulses.
REQ-029 Enqueue keys 5,2,9,2 (values 1,2,3,4) on consecutive cycles, then 4 dequeues -> kv_out sequence K2V2, K2V4, K5V1, K9V3, then empty=1.
REQ-030 Enqueue 16 entries, then one more enq -> full=1, count=16, ovf pulse, contents unchanged; then enq+deq with key 0 -> count stays 16, kv_out key 0.
REQ-031 Dequeue on empty queue -> udf pulse, count 0; enq+deq on empty with key 7 -> udf pulse, count=1, kv_out key 7.
REQ-032 Enqueue key FF -> key_err pulse, count unchanged.
REQ-033 Random 10k-cycle enq/deq/replace stream against a sorted-list reference model -> kv_out, count and flags match every cycle, including a random rst_n assertion mid-stream.
